router_credit_bank: RTL and testbench
=====================================

Name: router_credit_bank

Overview:
- Parametrised bank of output-VC credit counters for the DART router, one counter per (output port, VC) pair, NPORTS*NVCS counters in total.
- Replaces the fixed 10-VC x 4-bit credit composition: any port count, VC count and counter width.
- Adds per-VC max-credit registers, credit-return backpressure, a selected-credit lookup for the routing stage, a VC-allocation mask and sticky underflow error.
- Sits between the credit input ports and the route/VC-allocate stage; configured over the 16-bit data config chain.

Parameters:
NPORTS, 5, number of output ports
NVCS, 2, VCs per port
CC_WIDTH, 4, counter width; max credits 2^CC_WIDTH-1
LOG_NPORTS (local), max(1, CLogB2(NPORTS-1)), port index width
LOG_NVCS (local), max(1, CLogB2(NVCS-1)), VC index width
NINPUTS (local), NPORTS*NVCS, counter count; counter i = port i/NVCS, VC i%NVCS
CFG_WORDS (local), ceil(NINPUTS*CC_WIDTH/16), config words per full load

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
enable  in  1  global step enable; gates credit accept and decrement
config_in  in  16  config word
config_in_valid  in  1  config word strobe
config_out  out  16  word shifted out of chain top
config_out_valid  out  1  config_out strobe
credit_in_valid  in  NPORTS  credit return valid per port
credit_in_vc  in  NPORTS*LOG_NVCS  VC of returned credit, per port
credit_ack  out  NPORTS  credit accepted this cycle
use_valid  in  1  flit routed; consume one credit
use_port  in  LOG_NPORTS  port for lookup/consume
use_vc  in  LOG_NVCS  VC for lookup/consume
sel_credit  out  CC_WIDTH  count of counter (use_port,use_vc), combinational
vc_mask  out  NINPUTS  bit i = (count[i] != 0)
all_full  out  1  every count[i] == max[i] (no credits outstanding)
error  out  1  sticky error

Behaviour:
- Reset (async, active-high): all count = 0, all max = 0, config chain = 0, config_out = 0, config_out_valid = 0, error = 0. vc_mask = 0, all_full = 1, credit_ack = 0.
- Config chain: CFG_WORDS*16-bit shift register. On config_in_valid (independent of enable), shift left 16; config_in enters bits [15:0]; the top 16 bits are registered to config_out with config_out_valid = 1 for one cycle; otherwise config_out_valid = 0. max[i] = chain[i*CC_WIDTH +: CC_WIDTH]. Pad bits are ignored.
- Config write cycle: on config_in_valid, every count[i] is loaded with its new max[i] the same edge. Any simultaneous use/credit is dropped; credit_ack = 0 that cycle.
- Credit accept: credit_ack[p] = enable & credit_in_valid[p] & ~config_in_valid & (count[c] < max[c] | consume hits c), where c = p*NVCS + credit_in_vc[p]. A VC index >= NVCS is never acked and sets error. Each port addresses its own counters, so there are no cross-port conflicts.
- Consume: when enable & use_valid, counter u = use_port*NVCS + use_vc decrements. A port index >= NPORTS, or count[u] == 0 with no same-cycle credit, sets error and leaves the count unchanged.
- Simultaneous accepted credit and consume on the same counter: net unchanged.
- Updates are registered; they are visible on sel_credit/vc_mask one cycle after the edge.
- Out-of-range use_port/use_vc drives sel_credit = 0.
- enable low: counts hold, credit_ack = 0, use ignored, no error from use.
- error: sticky until reset; set on the edge after the offending cycle.

Test Plan:
- Default params. Reset, then 3 config words 0x4444 -> config_out_valid pulses 3 times (0x0000 each), all counts = 4, vc_mask = 0x3FF, all_full = 1.
- After config, use_valid port 2 VC 1 for 4 cycles -> sel_credit 4,3,2,1 then 0; vc_mask bit 5 clears; all_full = 0; error = 0.
- One further use on port 2 VC 1 with count 0 -> error = 1 next cycle and stays 1; count stays 0.
- Count[5] = 3, credit_in_valid[2] with vc 1 plus use on port 2 VC 1 in the same cycle -> credit_ack[2] = 1; count stays 3.
- Count[0] = max = 4, credit on port 0 VC 0 -> credit_ack[0] = 0, held until a consume on port 0 VC 0, then acked in that cycle.
- Reset asserted mid-stream with counts nonzero -> all outputs return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/router_credit_bank_if.sv
// Handshake and config bundle for the output-VC credit bank.
// Master drives config, credit returns and lookups; slave is the bank.
interface router_credit_bank_if #(
  parameter int NPORTS   = 5,
  parameter int NVCS     = 2,
  parameter int CC_WIDTH = 4
);
  localparam int LOG_NPORTS = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam int LOG_NVCS   = (NVCS > 1) ? $clog2(NVCS) : 1;
  localparam int NINPUTS    = NPORTS * NVCS;

  logic [15:0]                  config_in;
  logic                         config_in_valid;
  logic [15:0]                  config_out;
  logic                         config_out_valid;
  logic [NPORTS-1:0]            credit_in_valid;
  logic [NPORTS*LOG_NVCS-1:0]   credit_in_vc;
  logic [NPORTS-1:0]            credit_ack;
  logic                         use_valid;
  logic [LOG_NPORTS-1:0]        use_port;
  logic [LOG_NVCS-1:0]          use_vc;
  logic [CC_WIDTH-1:0]          sel_credit;
  logic [NINPUTS-1:0]           vc_mask;
  logic                         all_full;
  logic                         error;

  modport master (
    output config_in, config_in_valid,
    output credit_in_valid, credit_in_vc,
    output use_valid, use_port, use_vc,
    input  config_out, config_out_valid,
    input  credit_ack, sel_credit,
    input  vc_mask, all_full, error
  );

  modport slave (
    input  config_in, config_in_valid,
    input  credit_in_valid, credit_in_vc,
    input  use_valid, use_port, use_vc,
    output config_out, config_out_valid,
    output credit_ack, sel_credit,
    output vc_mask, all_full, error
  );
endinterface

// File: rtl/router_credit_bank.sv
// Per-(port,VC) output credit counters with config-chain loaded maxima,
// credit-return backpressure, routing lookup and sticky error.
module router_credit_bank #(
  parameter int NPORTS   = 5,
  parameter int NVCS     = 2,
  parameter int CC_WIDTH = 4
) (
  input logic                 clock,
  input logic                 reset,
  input logic                 enable,
  router_credit_bank_if.slave bus
);
  localparam int LOG_NVCS  = (NVCS > 1) ? $clog2(NVCS) : 1;
  localparam int NINPUTS   = NPORTS * NVCS;
  localparam int CFG_WORDS = (NINPUTS * CC_WIDTH + 15) / 16;
  localparam int CFG_BITS  = CFG_WORDS * 16;

  logic [CFG_BITS-1:0] chain_q, chain_d;
  logic [15:0]         cfg_out_q, cfg_out_d;
  logic                cfg_vld_q, cfg_vld_d;
  logic                error_q, error_d;
  logic [CC_WIDTH-1:0] count_q [NINPUTS];
  logic [CC_WIDTH-1:0] count_d [NINPUTS];
  logic [CC_WIDTH-1:0] max_cur [NINPUTS];
  logic [CC_WIDTH-1:0] max_new [NINPUTS];

  logic [NINPUTS-1:0]  use_hit;
  logic [NINPUTS-1:0]  credit_hit;
  logic [NPORTS-1:0]   ack;
  logic [CC_WIDTH-1:0] sel;
  logic                use_in;
  logic                use_go;
  logic                u_credit;
  logic                err_set;
  int                  use_idx;

  always_comb begin
    chain_d = chain_q;
    cfg_out_d = cfg_out_q;
    cfg_vld_d = 1'b0;
    if (bus.config_in_valid) begin
      chain_d = (chain_q << 16) | CFG_BITS'(bus.config_in);
      cfg_out_d = chain_q[CFG_BITS-1 -: 16];
      cfg_vld_d = 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < NINPUTS; i++) begin
      max_cur[i] = chain_q[i*CC_WIDTH +: CC_WIDTH];
      max_new[i] = chain_d[i*CC_WIDTH +: CC_WIDTH];
    end
  end

  always_comb begin
    use_idx = int'(bus.use_port) * NVCS + int'(bus.use_vc);
    use_in  = (int'(bus.use_port) < NPORTS) && (int'(bus.use_vc) < NVCS);
    use_go  = enable && bus.use_valid && !bus.config_in_valid;
    use_hit = '0;
    sel = '0;
    for (int i = 0; i < NINPUTS; i++) begin
      if (use_in && use_idx == i) begin
        sel = count_q[i];
        use_hit[i] = use_go;
      end
    end
  end

  // A full counter still accepts a credit when the same counter is consumed.
  always_comb begin
    ack = '0;
    credit_hit = '0;
    err_set = 1'b0;
    for (int p = 0; p < NPORTS; p++) begin
      if (enable && bus.credit_in_valid[p] && !bus.config_in_valid) begin
        if (int'(bus.credit_in_vc[p*LOG_NVCS +: LOG_NVCS]) >= NVCS)
          err_set = 1'b1;
        for (int v = 0; v < NVCS; v++) begin
          if (int'(bus.credit_in_vc[p*LOG_NVCS +: LOG_NVCS]) == v &&
              (count_q[p*NVCS+v] < max_cur[p*NVCS+v] ||
               use_hit[p*NVCS+v])) begin
            ack[p] = 1'b1;
            credit_hit[p*NVCS+v] = 1'b1;
          end
        end
      end
    end
    u_credit = |(credit_hit & use_hit);
    if (use_go && (!use_in || (sel == '0 && !u_credit)))
      err_set = 1'b1;
  end

  always_comb begin
    error_d = error_q | err_set;
    for (int i = 0; i < NINPUTS; i++) begin
      count_d[i] = count_q[i];
      if (bus.config_in_valid)
        count_d[i] = max_new[i];
      else if (credit_hit[i] && !use_hit[i])
        count_d[i] = count_q[i] + CC_WIDTH'(1);
      else if (use_hit[i] && !credit_hit[i] && count_q[i] != '0)
        count_d[i] = count_q[i] - CC_WIDTH'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      chain_q   <= '0;
      cfg_out_q <= '0;
      cfg_vld_q <= 1'b0;
      error_q   <= 1'b0;
      for (int i = 0; i < NINPUTS; i++)
        count_q[i] <= '0;
    end else begin
      chain_q   <= chain_d;
      cfg_out_q <= cfg_out_d;
      cfg_vld_q <= cfg_vld_d;
      error_q   <= error_d;
      for (int i = 0; i < NINPUTS; i++)
        count_q[i] <= count_d[i];
    end
  end

  always_comb begin
    bus.all_full = 1'b1;
    for (int i = 0; i < NINPUTS; i++) begin
      bus.vc_mask[i] = (count_q[i] != '0);
      if (count_q[i] != max_cur[i])
        bus.all_full = 1'b0;
    end
  end

  assign bus.credit_ack       = ack;
  assign bus.sel_credit       = sel;
  assign bus.config_out       = cfg_out_q;
  assign bus.config_out_valid = cfg_vld_q;
  assign bus.error            = error_q;
endmodule

// File: tb/tb_router_credit_bank.sv
// Directed bench for router_credit_bank at default parameters.
// Each task drives one scenario and checks against hand-computed values.
module tb_router_credit_bank;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic enable = 1'b0;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  router_credit_bank_if #(.NPORTS(5), .NVCS(2), .CC_WIDTH(4)) bus ();

  router_credit_bank #(.NPORTS(5), .NVCS(2), .CC_WIDTH(4)) dut (
    .clock  (clock),
    .reset  (reset),
    .enable (enable),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  task automatic idle_inputs();
    bus.config_in = 16'h0;
    bus.config_in_valid = 1'b0;
    bus.credit_in_valid = 5'b0;
    bus.credit_in_vc = 5'b0;
    bus.use_valid = 1'b0;
    bus.use_port = 3'd0;
    bus.use_vc = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    #12;
    total_cnt++;
    if (bus.vc_mask !== 10'h0)
      $display("FAIL rst_mask got %h want 000", bus.vc_mask);
    else pass_cnt++;
    total_cnt++;
    if (bus.all_full !== 1'b1)
      $display("FAIL rst_full got %b want 1", bus.all_full);
    else pass_cnt++;
    total_cnt++;
    if ({bus.error, bus.config_out_valid, bus.credit_ack} !== 7'b0)
      $display("FAIL rst_flags got %b want 0000000",
               {bus.error, bus.config_out_valid, bus.credit_ack});
    else pass_cnt++;
    total_cnt++;
    if (bus.config_out !== 16'h0)
      $display("FAIL rst_cfg_out got %h want 0000", bus.config_out);
    else pass_cnt++;
    @(negedge clock);
    reset = 1'b0;
    enable = 1'b1;
  endtask

  task automatic test_config();
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      bus.config_in = 16'h4444;
      bus.config_in_valid = 1'b1;
      @(posedge clock);
      #1;
      total_cnt++;
      if (bus.config_out_valid !== 1'b1 || bus.config_out !== 16'h0)
        $display("FAIL cfg_out%0d got %b/%h want 1/0000", k,
                 bus.config_out_valid, bus.config_out);
      else pass_cnt++;
    end
    @(negedge clock);
    bus.config_in_valid = 1'b0;
    @(posedge clock);
    #1;
    total_cnt++;
    if (bus.config_out_valid !== 1'b0)
      $display("FAIL cfg_vld_drop got %b want 0", bus.config_out_valid);
    else pass_cnt++;
    total_cnt++;
    if (bus.vc_mask !== 10'h3FF || bus.all_full !== 1'b1)
      $display("FAIL cfg_state got %h/%b want 3ff/1",
               bus.vc_mask, bus.all_full);
    else pass_cnt++;
  endtask

  task automatic test_consume();
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      bus.use_port = 3'd2;
      bus.use_vc = 1'b1;
      bus.use_valid = 1'b1;
      #1;
      total_cnt++;
      if (bus.sel_credit !== 4'(4 - k))
        $display("FAIL use_sel%0d got %0d want %0d", k,
                 bus.sel_credit, 4 - k);
      else pass_cnt++;
    end
    @(negedge clock);
    bus.use_valid = 1'b0;
    #1;
    total_cnt++;
    if (bus.sel_credit !== 4'd0 || bus.vc_mask !== 10'h3DF)
      $display("FAIL use_empty got %0d/%h want 0/3df",
               bus.sel_credit, bus.vc_mask);
    else pass_cnt++;
    total_cnt++;
    if (bus.all_full !== 1'b0 || bus.error !== 1'b0)
      $display("FAIL use_flags got %b/%b want 0/0",
               bus.all_full, bus.error);
    else pass_cnt++;
  endtask

  task automatic test_underflow();
    @(negedge clock);
    bus.use_valid = 1'b1;
    @(posedge clock);
    #1;
    total_cnt++;
    if (bus.error !== 1'b1 || bus.sel_credit !== 4'd0)
      $display("FAIL uflow got err %b sel %0d want 1/0",
               bus.error, bus.sel_credit);
    else pass_cnt++;
    @(negedge clock);
    bus.use_valid = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1;
    total_cnt++;
    if (bus.error !== 1'b1 || bus.sel_credit !== 4'd0)
      $display("FAIL uflow_sticky got err %b sel %0d want 1/0",
               bus.error, bus.sel_credit);
    else pass_cnt++;
  endtask

  task automatic test_same_cycle();
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      bus.credit_in_valid = 5'b00100;
      bus.credit_in_vc = 5'b00100;
      #1;
      total_cnt++;
      if (bus.credit_ack !== 5'b00100)
        $display("FAIL refill_ack%0d got %b want 00100", k, bus.credit_ack);
      else pass_cnt++;
    end
    @(negedge clock);
    bus.use_valid = 1'b1;
    #1;
    total_cnt++;
    if (bus.credit_ack !== 5'b00100 || bus.sel_credit !== 4'd3)
      $display("FAIL both_ack got %b/%0d want 00100/3",
               bus.credit_ack, bus.sel_credit);
    else pass_cnt++;
    @(negedge clock);
    bus.use_valid = 1'b0;
    bus.credit_in_valid = 5'b0;
    bus.credit_in_vc = 5'b0;
    #1;
    total_cnt++;
    if (bus.sel_credit !== 4'd3)
      $display("FAIL both_net got %0d want 3", bus.sel_credit);
    else pass_cnt++;
  endtask

  task automatic test_full_hold();
    @(negedge clock);
    bus.use_port = 3'd0;
    bus.use_vc = 1'b0;
    bus.credit_in_valid = 5'b00001;
    bus.credit_in_vc = 5'b00000;
    #1;
    total_cnt++;
    if (bus.credit_ack !== 5'b00000)
      $display("FAIL full_hold got %b want 00000", bus.credit_ack);
    else pass_cnt++;
    @(negedge clock);
    #1;
    total_cnt++;
    if (bus.credit_ack !== 5'b00000 || bus.sel_credit !== 4'd4)
      $display("FAIL full_hold2 got %b/%0d want 00000/4",
               bus.credit_ack, bus.sel_credit);
    else pass_cnt++;
    bus.use_valid = 1'b1;
    #1;
    total_cnt++;
    if (bus.credit_ack !== 5'b00001)
      $display("FAIL full_release got %b want 00001", bus.credit_ack);
    else pass_cnt++;
    @(negedge clock);
    bus.use_valid = 1'b0;
    bus.credit_in_valid = 5'b0;
    #1;
    total_cnt++;
    if (bus.sel_credit !== 4'd4)
      $display("FAIL full_net got %0d want 4", bus.sel_credit);
    else pass_cnt++;
  endtask

  task automatic test_enable_low();
    @(negedge clock);
    enable = 1'b0;
    bus.use_valid = 1'b1;
    bus.credit_in_valid = 5'b00010;
    bus.credit_in_vc = 5'b00000;
    #1;
    total_cnt++;
    if (bus.credit_ack !== 5'b00000)
      $display("FAIL en_ack got %b want 00000", bus.credit_ack);
    else pass_cnt++;
    @(negedge clock);
    bus.use_valid = 1'b0;
    bus.credit_in_valid = 5'b0;
    #1;
    total_cnt++;
    if (bus.sel_credit !== 4'd4)
      $display("FAIL en_hold got %0d want 4", bus.sel_credit);
    else pass_cnt++;
    bus.use_port = 3'd7;
    #1;
    total_cnt++;
    if (bus.sel_credit !== 4'd0)
      $display("FAIL oor_sel got %0d want 0", bus.sel_credit);
    else pass_cnt++;
    enable = 1'b1;
  endtask

  task automatic test_async_reset();
    @(negedge clock);
    bus.use_port = 3'd2;
    bus.use_vc = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    total_cnt++;
    if (bus.error !== 1'b0 || bus.vc_mask !== 10'h0)
      $display("FAIL arst_err got %b/%h want 0/000",
               bus.error, bus.vc_mask);
    else pass_cnt++;
    total_cnt++;
    if (bus.sel_credit !== 4'd0 || bus.all_full !== 1'b1)
      $display("FAIL arst_sel got %0d/%b want 0/1",
               bus.sel_credit, bus.all_full);
    else pass_cnt++;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_bad_port();
    @(negedge clock);
    bus.use_port = 3'd7;
    bus.use_valid = 1'b1;
    #1;
    total_cnt++;
    if (bus.error !== 1'b0)
      $display("FAIL badport_pre got %b want 0", bus.error);
    else pass_cnt++;
    @(posedge clock);
    #1;
    total_cnt++;
    if (bus.error !== 1'b1)
      $display("FAIL badport got %b want 1", bus.error);
    else pass_cnt++;
    @(negedge clock);
    bus.use_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_config();
    test_consume();
    test_underflow();
    test_same_cycle();
    test_full_hold();
    test_enable_low();
    test_async_reset();
    test_bad_port();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
